iot_event_scheduler: RTL and testbench

- Sits downstream of the per-channel IoT change detectors and takes their packed 2-bit change codes, one field per channel.
- Latches every non-zero code as a pending event per channel.
- Uses a round-robin arbiter to serialise pending events onto one valid/ready report port, with a programmable minimum gap between reports.
- Feeds the uplink/report logic so bursts of simultaneous changes on several devices are never merged or dropped silently.

---
 rtl/iot_event_scheduler_pkg.sv | 20 ++
 rtl/iot_event_scheduler_rr_arbiter.sv | 29 ++
 rtl/iot_event_scheduler.sv | 135 +++++++++++++
 tb/tb_iot_event_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iot_event_scheduler_pkg.sv
// Shared code constants, FSM encoding and sizing helper for the IoT event scheduler.
package iot_event_scheduler_pkg;

   localparam logic [1:0] CODE_NONE = 2'b00;
   localparam logic [1:0] CODE_RISE = 2'b01;
   localparam logic [1:0] CODE_FALL = 2'b10;
   localparam logic [1:0] CODE_BOTH = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   // Gap counter must hold GAP_CYCLES; keep at least one bit when the gap is disabled.
   function automatic int cnt_width(input int gap);
      return (gap > 0) ? $clog2(gap + 1) : 1;
   endfunction

endpackage

// File: rtl/iot_event_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping modulo N_CH.
module rr_arbiter #(
   parameter int N_CH = 3,
   parameter int CHW  = 2
) (
   input  logic [N_CH-1:0] req,
   input  logic [CHW-1:0]  ptr,
   output logic [N_CH-1:0] gnt,
   output logic [CHW-1:0]  gnt_idx,
   output logic            gnt_valid
);

   // Outer loop walks the priority order starting at ptr; only real channels can match.
   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         for (int i = 0; i < N_CH; i++) begin
            if (!gnt_valid && req[i] && (((int'(ptr) + k) % N_CH) == i)) begin
               gnt[i]    = 1'b1;
               gnt_idx   = CHW'(i);
               gnt_valid = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/iot_event_scheduler.sv
// Latches per-channel change codes as pending events and serialises them onto a
// valid/ready report port with round-robin fairness and a minimum inter-report gap.
module iot_event_scheduler
   import iot_event_scheduler_pkg::*;
#(
   parameter int N_CH       = 3,
   parameter int CHW        = 2,
   parameter int GAP_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [2*N_CH-1:0] data_in,
   input  logic              ev_ready,
   input  logic              clr_overflow,
   output logic              ev_valid,
   output logic [CHW-1:0]    ev_ch,
   output logic [1:0]        ev_code,
   output logic [N_CH-1:0]   pending,
   output logic [N_CH-1:0]   overflow,
   output logic              busy
);

   localparam int              CNT_W    = cnt_width(GAP_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);

   state_e                 state_q, state_d;
   logic [N_CH-1:0]        pend_q, pend_d;
   logic [N_CH-1:0][1:0]   pend_code_q, pend_code_d;
   logic [N_CH-1:0]        ovf_q, ovf_d;
   logic [CHW-1:0]         ptr_q, ptr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CHW-1:0]         ev_ch_q, ev_ch_d;
   logic [1:0]             ev_code_q, ev_code_d;

   logic [N_CH-1:0]        gnt;
   logic [CHW-1:0]         gnt_idx;
   logic                   gnt_valid;
   logic                   take;
   logic                   accept;

   rr_arbiter #(
      .N_CH (N_CH),
      .CHW  (CHW)
   ) u_arb (
      .req       (pend_q),
      .ptr       (ptr_q),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (gnt_valid) state_d = ST_SEND;
         ST_SEND: if (ev_ready)  state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
         ST_GAP:  if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      take     = (state_q == ST_IDLE) && gnt_valid;
      accept   = (state_q == ST_SEND) && ev_ready;
      ev_valid = (state_q == ST_SEND);
      busy     = (state_q != ST_IDLE) || (|pend_q);
   end

   // A capture on a channel being granted this cycle starts a fresh event, not an overflow.
   always_comb begin
      pend_d      = pend_q;
      pend_code_d = pend_code_q;
      ovf_d       = clr_overflow ? '0 : ovf_q;
      for (int i = 0; i < N_CH; i++) begin
         if (en && (data_in[2*i +: 2] != CODE_NONE)) begin
            if (pend_q[i] && !(take && gnt[i])) ovf_d[i] = 1'b1;
            pend_d[i]      = 1'b1;
            pend_code_d[i] = data_in[2*i +: 2];
         end else if (take && gnt[i]) begin
            pend_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      ev_ch_d   = ev_ch_q;
      ev_code_d = ev_code_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      if (take) begin
         ev_ch_d = gnt_idx;
         for (int i = 0; i < N_CH; i++) begin
            if (gnt[i]) ev_code_d = pend_code_q[i];
         end
         ptr_d = (gnt_idx == CHW'(N_CH - 1)) ? '0 : gnt_idx + CHW'(1);
      end
      if (accept) begin
         cnt_d = GAP_LOAD;
      end else if (state_q == ST_GAP) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q      <= '0;
         pend_code_q <= '0;
         ovf_q       <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         ev_ch_q     <= '0;
         ev_code_q   <= '0;
      end else begin
         pend_q      <= pend_d;
         pend_code_q <= pend_code_d;
         ovf_q       <= ovf_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         ev_ch_q     <= ev_ch_d;
         ev_code_q   <= ev_code_d;
      end
   end

   assign ev_ch    = ev_ch_q;
   assign ev_code  = ev_code_q;
   assign pending  = pend_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_iot_event_scheduler.sv
// Directed scenarios plus randomized traffic checked against a queue-style reference model.
module tb_iot_event_scheduler;
   import iot_event_scheduler_pkg::*;

   localparam int N_CH = 3;
   localparam int CHW  = 2;
   localparam int GAP  = 4;

   logic              clk = 1'b0;
   logic              rst, en, ev_ready, clr_overflow;
   logic [2*N_CH-1:0] data_in;
   logic              ev_valid, busy;
   logic [CHW-1:0]    ev_ch;
   logic [1:0]        ev_code;
   logic [N_CH-1:0]   pending, overflow;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Reference model: pending events, sticky overflow, fairness pointer,
   // the report in flight and the number of enforced idle cycles left.
   logic [N_CH-1:0] m_pend, m_ovf;
   logic [1:0]      m_code [N_CH];
   int              m_ptr, m_ch, m_gap;
   logic [1:0]      m_cd;
   bit              m_inf;

   iot_event_scheduler #(.N_CH(N_CH), .CHW(CHW), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst), .en(en), .data_in(data_in), .ev_ready(ev_ready),
      .clr_overflow(clr_overflow), .ev_valid(ev_valid), .ev_ch(ev_ch),
      .ev_code(ev_code), .pending(pending), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic model_update();
      int g;
      logic [1:0] c;
      g = -1;
      if (rst) begin
         m_pend = '0; m_ovf = '0; m_ptr = 0; m_inf = 0; m_gap = 0; m_ch = 0; m_cd = 2'b00;
         for (int i = 0; i < N_CH; i++) m_code[i] = 2'b00;
      end else begin
         if (!m_inf && m_gap == 0) begin
            for (int k = 0; k < N_CH; k++)
               if (g < 0 && m_pend[(m_ptr + k) % N_CH]) g = (m_ptr + k) % N_CH;
         end else if (m_inf && ev_ready) begin
            m_inf = 0; m_gap = GAP;
         end else if (m_gap > 0) begin
            m_gap--;
         end
         if (g >= 0) begin
            m_inf = 1; m_ch = g; m_cd = m_code[g]; m_ptr = (g + 1) % N_CH;
         end
         if (clr_overflow) m_ovf = '0;
         for (int i = 0; i < N_CH; i++) begin
            c = data_in[2*i +: 2];
            if (en && c != CODE_NONE) begin
               if (m_pend[i] && g != i) m_ovf[i] = 1'b1;
               m_pend[i] = 1'b1; m_code[i] = c;
            end else if (g == i) begin
               m_pend[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1; en = 1; data_in = '0; ev_ready = 0; clr_overflow = 0;
      step();
      rst = 0;
   endtask

   task automatic test_reset();
      ev_ready = 1; data_in = 6'b010101;
      step();
      do_reset();
      n_chk++; if (ev_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ev_valid); else n_pass++;
      n_chk++; if (ev_ch !== 2'd0 || ev_code !== 2'd0) $display("FAIL reset_ch_code got %0d/%b want 0/00", ev_ch, ev_code); else n_pass++;
      n_chk++; if (pending !== 3'b000 || overflow !== 3'b000) $display("FAIL reset_pend_ovf got %b/%b want 000/000", pending, overflow); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_single();
      int nv;
      do_reset();
      ev_ready = 1; data_in = {CODE_NONE, CODE_NONE, CODE_RISE};
      step();
      data_in = '0;
      n_chk++; if (pending !== 3'b001 || ev_valid !== 1'b0) $display("FAIL single_capture got pend=%b valid=%b want 001/0", pending, ev_valid); else n_pass++;
      step();
      n_chk++; if (ev_valid !== 1'b1 || ev_ch !== 2'd0 || ev_code !== CODE_RISE) $display("FAIL single_report got v=%b ch=%0d code=%b want 1/0/01", ev_valid, ev_ch, ev_code); else n_pass++;
      step();
      nv = 0;
      for (int i = 0; i < 3; i++) begin if (ev_valid) nv++; step(); end
      n_chk++; if (nv != 0 || busy !== 1'b1) $display("FAIL single_gap got valids=%0d busy=%b want 0/1", nv, busy); else n_pass++;
      step();
      n_chk++; if (busy !== 1'b0) $display("FAIL single_idle got busy=%b want 0", busy); else n_pass++;
   endtask

   task automatic test_burst();
      int rc[$], rcode[$], rt[$];
      do_reset();
      ev_ready = 1; data_in = {CODE_FALL, CODE_FALL, CODE_RISE};
      step();
      data_in = '0;
      for (int i = 0; i < 30; i++) begin
         if (ev_valid) begin rc.push_back(int'(ev_ch)); rcode.push_back(int'(ev_code)); rt.push_back(cyc); end
         step();
      end
      n_chk++;
      if (rc.size() != 3) $display("FAIL burst_count got %0d want 3", rc.size());
      else if (rc[0] != 0 || rc[1] != 1 || rc[2] != 2 || rcode[0] != 1 || rcode[1] != 2 || rcode[2] != 2)
         $display("FAIL burst_order got %0d/%0d %0d/%0d %0d/%0d want 0/1 1/2 2/2", rc[0], rcode[0], rc[1], rcode[1], rc[2], rcode[2]);
      else n_pass++;
      n_chk++;
      if (rt.size() != 3 || rt[1] - rt[0] != GAP + 2 || rt[2] - rt[1] != GAP + 2)
         $display("FAIL burst_spacing got %0d reports want spacing %0d", rt.size(), GAP + 2);
      else n_pass++;
      n_chk++; if (overflow !== 3'b000) $display("FAIL burst_ovf got %b want 000", overflow); else n_pass++;
   endtask

   task automatic test_backpressure();
      bit stable;
      do_reset();
      ev_ready = 0; data_in = {CODE_NONE, CODE_RISE, CODE_NONE};
      step();
      data_in = '0;
      step();
      stable = 1;
      for (int i = 0; i < 10; i++) begin
         if (ev_valid !== 1'b1 || ev_ch !== 2'd1 || ev_code !== CODE_RISE) stable = 0;
         step();
      end
      n_chk++; if (!stable || ev_valid !== 1'b1) $display("FAIL bp_stable got v=%b ch=%0d code=%b want 1/1/01 held", ev_valid, ev_ch, ev_code); else n_pass++;
      ev_ready = 1;
      step();
      n_chk++; if (ev_valid !== 1'b0) $display("FAIL bp_accept got valid=%b want 0", ev_valid); else n_pass++;
   endtask

   task automatic test_overflow();
      int code2;
      do_reset();
      ev_ready = 0; data_in = {CODE_RISE, CODE_NONE, CODE_RISE};
      step();
      data_in = '0;
      step();
      data_in = {CODE_FALL, CODE_NONE, CODE_NONE};
      step();
      data_in = '0;
      n_chk++; if (overflow !== 3'b100 || pending !== 3'b100) $display("FAIL ovf_set got ovf=%b pend=%b want 100/100", overflow, pending); else n_pass++;
      ev_ready = 1;
      code2 = -1;
      for (int i = 0; i < 20; i++) begin
         if (ev_valid && ev_ch == 2'd2 && code2 < 0) code2 = int'(ev_code);
         step();
      end
      n_chk++; if (code2 != 2) $display("FAIL ovf_code got %0d want 2", code2); else n_pass++;
      clr_overflow = 1;
      step();
      clr_overflow = 0;
      n_chk++; if (overflow !== 3'b000) $display("FAIL ovf_clear got %b want 000", overflow); else n_pass++;
   endtask

   task automatic test_enable();
      int nv;
      bit leak, saw;
      do_reset();
      ev_ready = 1; data_in = {CODE_NONE, CODE_NONE, CODE_BOTH};
      step();
      en = 0; data_in = 6'b111111;
      nv = 0; leak = 0; saw = 0;
      for (int i = 0; i < 15; i++) begin
         if (pending[2:1] !== 2'b00) leak = 1;
         if (ev_valid) begin nv++; if (ev_ch == 2'd0 && ev_code == CODE_BOTH) saw = 1; end
         step();
      end
      n_chk++; if (leak || pending !== 3'b000) $display("FAIL en_ignore got pend=%b leak=%0d want 000/0", pending, leak); else n_pass++;
      n_chk++; if (nv != 1 || !saw) $display("FAIL en_drain got reports=%0d ch0_seen=%0d want 1/1", nv, saw); else n_pass++;
      en = 1; data_in = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      ev_ready = 0; data_in = {CODE_RISE, CODE_RISE, CODE_RISE};
      step();
      data_in = '0;
      step();
      n_chk++; if (ev_valid !== 1'b1 || pending !== 3'b110) $display("FAIL rstmid_pre got v=%b pend=%b want 1/110", ev_valid, pending); else n_pass++;
      rst = 1;
      step();
      rst = 0;
      n_chk++; if (ev_valid !== 1'b0 || pending !== 3'b000) $display("FAIL rstmid_drop got v=%b pend=%b want 0/000", ev_valid, pending); else n_pass++;
      data_in = {CODE_RISE, CODE_RISE, CODE_RISE};
      step();
      data_in = '0;
      step();
      n_chk++; if (ev_valid !== 1'b1 || ev_ch !== 2'd0) $display("FAIL rstmid_ptr got v=%b ch=%0d want 1/0", ev_valid, ev_ch); else n_pass++;
   endtask

   task automatic test_random();
      int bad;
      do_reset();
      for (int t = 0; t < 600; t++) begin
         rst          = ($urandom_range(0, 149) == 0);
         en           = ($urandom_range(0, 9) != 0);
         ev_ready     = ($urandom_range(0, 2) != 0);
         clr_overflow = ($urandom_range(0, 15) == 0);
         for (int i = 0; i < N_CH; i++)
            data_in[2*i +: 2] = ($urandom_range(0, 9) < 7) ? CODE_NONE : 2'($urandom_range(1, 3));
         step();
         bad = 0;
         if (ev_valid !== m_inf) bad = 1;
         if (m_inf && (int'(ev_ch) != m_ch || ev_code !== m_cd)) bad = 1;
         if (pending !== m_pend || overflow !== m_ovf) bad = 1;
         if (busy !== (m_inf || m_gap > 0 || (|m_pend))) bad = 1;
         n_chk++;
         if (bad) $display("FAIL rand_cyc%0d got v=%b ch=%0d code=%b pend=%b ovf=%b busy=%b want v=%0d ch=%0d code=%b pend=%b ovf=%b",
                           cyc, ev_valid, ev_ch, ev_code, pending, overflow, busy, m_inf, m_ch, m_cd, m_pend, m_ovf);
         else n_pass++;
      end
      rst = 0; clr_overflow = 0; data_in = '0;
   endtask

   initial begin
      rst = 1; en = 1; data_in = '0; ev_ready = 0; clr_overflow = 0;
      test_reset();
      test_single();
      test_burst();
      test_backpressure();
      test_overflow();
      test_enable();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
